// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Multi-cycle HI/LO multiply/divide unit with mthi/mtlo support.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] C_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_div;
  logic        r_uns;

  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Sign-extending to 64 bits makes the truncated unsigned product the signed one.
  assign w_prod = r_uns ? ({32'b0, r_a} * {32'b0, r_b})
                        : ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b});

  // Signed division via magnitudes: quotient truncates toward zero and the
  // remainder follows the dividend; 0x80000000 / -1 wraps naturally.
  assign w_a_neg  = !r_uns && r_a[31];
  assign w_b_neg  = !r_uns && r_b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quo    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_div   <= 1'b0;
      r_uns   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (MDOp)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_a     <= A;
                r_b     <= B;
                r_div   <= MDOp[1];
                r_uns   <= MDOp[0];
                r_cnt   <= MDOp[1] ? C_DIV_N : C_MULT_N;
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              3'b100:  r_hi <= A;
              3'b101:  r_lo <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            if (!r_div) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (r_b != 32'd0) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Scoreboard bench for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  MDOp = 3'b111;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDOp(MDOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sbv;
    logic [63:0] r, q, rm;
    r = {hi, lo};
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'd0: r = sa * sbv;
      3'd1: r = {32'b0, a} * {32'b0, b};
      3'd2: if (b != 0) begin q = sa / sbv; rm = sa % sbv; r = {rm[31:0], q[31:0]}; end
      3'd3: if (b != 0) r = {a % b, a / b};
      3'd4: r = {a, lo};
      3'd5: r = {hi, a};
      default: ;
    endcase
    return r;
  endfunction

  // Issue one request (accepted at the next rising edge) and count busy cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; MDOp = op; A = a; B = b;
    e = model(op, a, b, m_hi, m_lo);
    sb.push_back(e);
    {m_hi, m_lo} = e;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", LO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult();
    int n; logic [63:0] e;
    do_op(3'd0, 32'hFFFFFFFE, 32'd3, n); e = sb.pop_front();
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_lat: got %0d want 5", n); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mult_res: got %h_%h want %h", HI, LO, e); end
    do_op(3'd1, 32'hFFFFFFFE, 32'd3, n); e = sb.pop_front();
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_lat: got %0d want 5", n); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL multu_res: got %h_%h want %h", HI, LO, e); end
  endtask

  task automatic test_div();
    int n; logic [63:0] e;
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, n); e = sb.pop_front();
    checks++; if (n !== 10) begin errors++; $display("FAIL div_lat: got %0d want 10", n); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL div_res: got %h_%h want %h", HI, LO, e); end
    do_op(3'd3, 32'd7, 32'd2, n); e = sb.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL divu_res: got %h_%h want %h", HI, LO, e); end
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n); e = sb.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL div_ovf: got %h_%h want %h", HI, LO, e); end
    for (int i = 0; i < 6; i++) begin
      do_op(3'(i % 4), $urandom, (i == 5) ? 32'd13 : $urandom, n); e = sb.pop_front();
      checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL rand_%0d: got %h_%h want %h", i, HI, LO, e); end
    end
  endtask

  task automatic test_mthi_divzero();
    int n; logic [63:0] e;
    do_op(3'd4, 32'h12345678, 32'd0, n); e = sb.pop_front();
    checks++; if (n !== 0) begin errors++; $display("FAIL mthi_busy: got %0d want 0", n); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mthi_res: got %h_%h want %h", HI, LO, e); end
    do_op(3'd5, 32'hA5A5A5A5, 32'd0, n); e = sb.pop_front();
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mtlo_res: got %h_%h want %h", HI, LO, e); end
    do_op(3'd3, 32'd99, 32'd0, n); e = sb.pop_front();
    checks++; if (n !== 10) begin errors++; $display("FAIL divz_lat: got %0d want 10", n); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL divz_res: got %h_%h want %h", HI, LO, e); end
    do_op(3'd6, 32'hFFFF0000, 32'd1, n); e = sb.pop_front();
    checks++; if ({HI, LO, 1'b0} !== {e, busy}) begin errors++; $display("FAIL nop_res: got %h_%h busy=%b want %h", HI, LO, busy, e); end
  endtask

  task automatic test_ignore_busy();
    int n; logic [63:0] e, hold;
    hold = {m_hi, m_lo};
    @(negedge clk);
    start = 1'b1; MDOp = 3'd0; A = 32'h10000; B = 32'h10000;
    e = model(3'd0, A, B, m_hi, m_lo);
    sb.push_back(e); {m_hi, m_lo} = e;
    @(posedge clk); #1;
    n = 0;
    while (busy && n < 40) begin
      checks++; if ({HI, LO} !== hold) begin errors++; $display("FAIL hold_%0d: got %h_%h want %h", n, HI, LO, hold); end
      start = (n < 3); MDOp = 3'd5; A = (n == 0) ? 32'hDEADBEEF : $urandom; B = $urandom;
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++; if (n !== 5) begin errors++; $display("FAIL ign_lat: got %0d want 5", n); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL ign_res: got %h_%h want %h", HI, LO, e); end
  endtask

  task automatic test_back_to_back();
    int n1, n2; logic [63:0] e;
    do_op(3'd0, 32'd3, 32'd4, n1); e = sb.pop_front();
    checks++; if (LO !== e[31:0]) begin errors++; $display("FAIL b2b_first: got %h want %h", LO, e[31:0]); end
    do_op(3'd0, 32'd5, 32'd6, n2); e = sb.pop_front();
    checks++; if (LO !== e[31:0]) begin errors++; $display("FAIL b2b_second: got %h want %h", LO, e[31:0]); end
    checks++; if (n1 + n2 !== 10) begin errors++; $display("FAIL b2b_busy: got %0d want 10", n1 + n2); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if ({HI, LO, busy} !== 65'd0) begin errors++; $display("FAIL abort_now: got %h_%h busy=%b want 0", HI, LO, busy); end
    @(negedge clk); start = 1'b1; MDOp = 3'd4; A = 32'hCAFE0000;
    @(posedge clk); #1;
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL start_in_reset: got %h want 00000000", HI); end
    @(negedge clk); start = 1'b0; reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (15) @(posedge clk);
    #1;
    checks++; if ({HI, LO, busy} !== 65'd0) begin errors++; $display("FAIL abort_late: got %h_%h busy=%b want 0", HI, LO, busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_divzero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
